sid_filter_seq: RTL and testbench

- Sequencer and state store on the other side of the SID filter's stage-driven interface.
- Time-multiplexes one filter datapath across N_SID SID instances.
- Per sample tick: drives the 3-bit stage sequence and the instance select, presents each instance's stored vhp/vbp/vlp state to the filter, writes back the updated state, and captures the per-instance 22-bit audio result.

---
 rtl/sid_filter_seq.sv | 148 ++++++++++++++
 tb/tb_sid_filter_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sid_filter_seq.sv
// Sequencer and per-instance state store that time-multiplexes one SID filter
// datapath across N_SID instances, one 8-cycle stage sweep per instance per tick.
module sid_filter_seq #(
  parameter int unsigned N_SID = 2,
  parameter int unsigned SEL_W = (N_SID > 1) ? $clog2(N_SID) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_i,
  input  logic [N_SID-1:0]        clear_i,
  input  logic [47:0]             state_i,
  input  logic [21:0]             audio_i,
  output logic [2:0]              stage_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic [47:0]             state_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic [21:0]             audio_o,
  output logic [SEL_W-1:0]        audio_sel_o,
  output logic                    audio_valid_o,
  output logic [22+SEL_W-1:0]     mix_o,
  output logic                    mix_valid_o
);

  localparam int unsigned AW = 22;
  localparam int unsigned SW = 48;
  localparam int unsigned MW = AW + SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SID - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       stage_d;
  logic [SEL_W-1:0] sel_d;
  logic             wb_c;
  logic             last_c;
  logic [N_SID-1:0] act_c;

  logic [SW-1:0]    slot_q [N_SID];
  logic [N_SID-1:0] pend_q;
  logic [MW-1:0]    acc_q;
  logic             mix_pend_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, stage/instance stepping and writeback strobe
  always_comb begin
    state_d = state_q;
    stage_d = stage_o;
    sel_d   = sel_o;
    wb_c    = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_i) begin
          state_d = RUN;
          stage_d = 3'd1;
          sel_d   = '0;
        end
      end
      RUN: begin
        stage_d = stage_o + 3'd1;
        if (stage_o == 3'd0) begin
          wb_c = 1'b1;
          if (sel_o == LAST_SEL) begin
            last_c  = 1'b1;
            state_d = IDLE;
            stage_d = 3'd0;
            sel_d   = '0;
          end else begin
            stage_d = 3'd1;
            sel_d   = sel_o + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot of the instance currently owned by the filter
  always_comb begin
    act_c = '0;
    if (state_q == RUN) begin
      for (int unsigned k = 0; k < N_SID; k++) begin
        act_c[k] = (sel_o == SEL_W'(k));
      end
    end
  end

  assign state_o = slot_q[sel_o];

  // State store: clears on idle slots act at once, on the active slot they replace the writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_SID; k++) slot_q[k] <= '0;
      pend_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_SID; k++) begin
        if (act_c[k]) begin
          if (wb_c) begin
            slot_q[k] <= (pend_q[k] || clear_i[k]) ? '0 : state_i;
            pend_q[k] <= 1'b0;
          end else if (clear_i[k]) begin
            pend_q[k] <= 1'b1;
          end
        end else if (clear_i[k]) begin
          slot_q[k] <= '0;
        end
      end
    end
  end

  // Sequencer outputs, audio capture and mix accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_o       <= '0;
      sel_o         <= '0;
      busy_o        <= 1'b0;
      overrun_o     <= 1'b0;
      audio_o       <= '0;
      audio_sel_o   <= '0;
      audio_valid_o <= 1'b0;
      acc_q         <= '0;
      mix_pend_q    <= 1'b0;
      mix_o         <= '0;
      mix_valid_o   <= 1'b0;
    end else begin
      stage_o       <= stage_d;
      sel_o         <= sel_d;
      busy_o        <= (state_d == RUN);
      overrun_o     <= tick_i && (state_q == RUN);
      audio_valid_o <= wb_c;
      mix_pend_q    <= last_c;
      mix_valid_o   <= mix_pend_q;
      if (wb_c) begin
        audio_o     <= audio_i;
        audio_sel_o <= sel_o;
        acc_q       <= ((sel_o == '0) ? '0 : acc_q) + {{SEL_W{audio_i[AW-1]}}, audio_i};
      end
      if (mix_pend_q) mix_o <= acc_q;
    end
  end

endmodule

// File: tb/tb_sid_filter_seq.sv
// Randomized bench for sid_filter_seq: cycle-count reference model plus
// audio/mix scoreboard queues drained by an independent monitor.
module tb_sid_filter_seq;

  localparam int unsigned N_SID = 2;
  localparam int unsigned SEL_W = 1;
  localparam int unsigned MW    = 22 + SEL_W;
  localparam int          RLEN  = 8 * N_SID;

  logic             clk;
  logic             rst_n;
  logic             tick_i;
  logic [N_SID-1:0] clear_i;
  logic [47:0]      state_i;
  logic [21:0]      audio_i;
  logic [2:0]       stage_o;
  logic [SEL_W-1:0] sel_o;
  logic [47:0]      state_o;
  logic             busy_o;
  logic             overrun_o;
  logic [21:0]      audio_o;
  logic [SEL_W-1:0] audio_sel_o;
  logic             audio_valid_o;
  logic [MW-1:0]    mix_o;
  logic             mix_valid_o;

  sid_filter_seq #(.N_SID(N_SID)) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .clear_i(clear_i),
    .state_i(state_i), .audio_i(audio_i), .stage_o(stage_o), .sel_o(sel_o),
    .state_o(state_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .audio_o(audio_o), .audio_sel_o(audio_sel_o), .audio_valid_o(audio_valid_o),
    .mix_o(mix_o), .mix_valid_o(mix_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: j counts cycles into the round (0 = idle)
  int          j;
  int          cyc;
  logic [47:0] m_slot [N_SID];
  bit          m_pend [N_SID];
  longint      m_acc;
  bit          e_ovr, e_av, e_mv, e_last;
  int          q_asel [$];
  longint      q_aud  [$];
  longint      q_mix  [$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    j = 0;
    for (int k = 0; k < N_SID; k++) begin
      m_slot[k] = '0;
      m_pend[k] = 1'b0;
    end
    m_acc = 0; e_ovr = 0; e_av = 0; e_mv = 0; e_last = 0;
    q_asel.delete(); q_aud.delete(); q_mix.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stage"}, longint'(stage_o), 0);
    chk({tag, "_sel"}, longint'(sel_o), 0);
    chk({tag, "_busy"}, longint'(busy_o), 0);
    chk({tag, "_overrun"}, longint'(overrun_o), 0);
    chk({tag, "_audio"}, longint'(audio_o), 0);
    chk({tag, "_audio_sel"}, longint'(audio_sel_o), 0);
    chk({tag, "_audio_valid"}, longint'(audio_valid_o), 0);
    chk({tag, "_mix"}, longint'(mix_o), 0);
    chk({tag, "_mix_valid"}, longint'(mix_valid_o), 0);
    chk({tag, "_state"}, longint'(state_o), 0);
  endtask

  // One cycle: check current outputs, drive inputs, advance model, step to edge+1
  // mode 0 = directed scenario, 1 = random, 2 = quiet, 3 = tick only
  task automatic step(input int mode);
    int               es, esel, act;
    bit               wb;
    logic             t;
    logic [N_SID-1:0] c;
    logic [47:0]      s;
    logic [21:0]      a;
    longint           sa;
    es   = (j == 0) ? 0 : j % 8;
    esel = (j == 0) ? 0 : (j - 1) / 8;
    chk("stage_o", longint'(stage_o), es);
    chk("sel_o", longint'(sel_o), esel);
    chk("busy_o", longint'(busy_o), (j != 0) ? 1 : 0);
    chk("state_o", longint'(state_o), longint'(m_slot[esel]));
    chk("overrun_o", longint'(overrun_o), e_ovr);
    chk("audio_valid_o", longint'(audio_valid_o), e_av);
    chk("mix_valid_o", longint'(mix_valid_o), e_mv);

    s = {16'($urandom), 32'($urandom)};
    a = 22'($urandom);
    if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 22'h200000 : 22'h1fffff;
    t = 1'b0;
    c = '0;
    case (mode)
      0: begin
        t = (cyc == 2) || (cyc == 7) || (cyc == 18) || (cyc == 19);
        if (cyc <= 19) begin
          s = 48'h0001_0002_0003;
          a = (esel == 0) ? 22'(200000) : 22'(-50000);
        end else begin
          s = 48'h1234_5678_9abc;
          a = 22'(-2097152);
          if (j == 2) c = 2'b10;
          if (j == 3) c = 2'b01;
        end
      end
      1: begin
        t = (j == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 11) == 0);
        for (int k = 0; k < N_SID; k++) c[k] = ($urandom_range(0, 9) == 0);
      end
      3: t = 1'b1;
      default: ;
    endcase
    tick_i  = t;
    clear_i = c;
    state_i = s;
    audio_i = a;

    act    = (j == 0) ? -1 : esel;
    wb     = (j != 0) && (es == 0);
    e_ovr  = t && (j != 0);
    e_mv   = e_last;
    e_av   = 0;
    e_last = 0;
    for (int k = 0; k < N_SID; k++) begin
      if (c[k]) begin
        if (k == act) m_pend[k] = 1'b1;
        else          m_slot[k] = '0;
      end
    end
    if (wb) begin
      sa = longint'($signed(a));
      m_slot[act] = m_pend[act] ? 48'h0 : s;
      m_pend[act] = 1'b0;
      q_asel.push_back(act);
      q_aud.push_back(sa);
      m_acc = ((act == 0) ? 0 : m_acc) + sa;
      e_av  = 1;
      if (act == N_SID - 1) begin
        e_last = 1;
        q_mix.push_back(m_acc);
      end
    end
    if (j == 0)         j = t ? 1 : 0;
    else if (j == RLEN) j = 0;
    else                j = j + 1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains the scoreboard whenever the DUT flags a new result
  always @(negedge clk) begin
    if (rst_n) begin
      if (audio_valid_o) begin
        if (q_aud.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL audio_unexpected: got audio %0d with nothing expected", $signed(audio_o));
        end else begin
          chk("audio_sel_o", longint'(audio_sel_o), longint'(q_asel.pop_front()));
          chk("audio_o", longint'($signed(audio_o)), q_aud.pop_front());
        end
      end
      if (mix_valid_o) begin
        if (q_mix.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mix_unexpected: got mix %0d with nothing expected", $signed(mix_o));
        end else begin
          chk("mix_o", longint'($signed(mix_o)), q_mix.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    tick_i  = 1'b0;
    clear_i = '0;
    state_i = '0;
    audio_i = '0;
    cyc     = 0;
    model_reset();
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) step(0);
    for (int i = 0; i < 1500; i++) step(1);

    // Abort a round mid-flight with an asynchronous reset
    for (int i = 0; i < 40 && j != 0; i++) step(2);
    step(3);
    for (int i = 0; i < 8 && j != 4; i++) step(2);
    chk("pre_reset_stage", longint'(stage_o), 4);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(2);
    for (int i = 0; i < 300; i++) step(1);
    for (int i = 0; i < 2 * RLEN + 4; i++) step(2);

    chk("audio_q_left", longint'(q_aud.size()), 0);
    chk("mix_q_left", longint'(q_mix.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
